i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
//  Single-byte I2C bus master that drives the scl/sda lines consumed by i2c_slave in topmodule_i2c.
//  Per request it issues START, 7-bit address + R/W, one data byte (write or read), then STOP.
//  Lines are open-drain: pulled low or released, never driven high. No multi-master arbitration,
//  no clock stretching.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV clk (CLK_DIV >= 2)
// PORTS
//  clk         in     1  system clock, all logic on rising edge
//  reset       in     1  synchronous, active-high reset
//  start       in     1  request a transaction; sampled only when busy=0
//  slave_addr  in     7  target address, latched on accepted start
//  rw          in     1  0 = write data_in, 1 = read into data_out; latched on accepted start
//  data_in     in     8  byte to write, latched on accepted start
//  ack_master  in     1  1 = master ACKs (sda low) the read byte, 0 = NACK; sampled in READ_ACK
//  data_out    out    8  byte read from slave; valid when done=1 and rw=1
//  busy        out    1  high from accepted start through the end of STOP
//  done        out    1  one-clk pulse when the transaction ends
//  ack_error   out    1  slave NACKed the address or write byte; sticky until the next accepted start
//  scl         inout  1  I2C clock: 1'b0 when scl_low, else 1'bz
//  sda         inout  1  I2C data: 1'b0 when sda_low, else 1'bz
// BEHAVIOUR
//  Reset: IDLE; scl/sda released; busy=0, done=0, ack_error=0, data_out=8'h00; counters cleared.
//  Reset mid-transfer: lines released on the next edge. No STOP is generated.
//  Timing: quarter counter qcnt 0..3, advancing every CLK_DIV clk.
//    Bit slot = 4 quarters. q0: SCL low, SDA updates. q1-q2: SCL released (high); SDA sampled at the
//    end of q1. q3: SCL low.
//  FSM, one slot per state unless noted:
//    IDLE: lines released. start & !busy -> latch {slave_addr,rw}, data_in; clear ack_error; go START.
//    START: SDA falls while SCL is high (q1), then SCL goes low -> ADDR.
//    ADDR: 8 slots, MSB first, shifting {addr,rw} -> ADDR_ACK.
//    ADDR_ACK: SDA released, sampled. NACK -> ack_error=1, STOP. ACK -> WRITE if rw=0, else READ.
//    WRITE: 8 slots, data MSB first -> WRITE_ACK.
//    WRITE_ACK: SDA released, sampled. NACK sets ack_error. Always -> STOP.
//    READ: SDA released, 8 slots. Shift sampled bit into data_out LSB; MSB is received first.
//    READ_ACK: drive SDA low if ack_master=1, else release -> STOP.
//    STOP: q0 SDA low with SCL low; q1 SCL released; q2 SDA released (rising SDA while SCL high);
//      end of slot -> IDLE with done=1 for one clk, busy=0.
//  start while busy: ignored and not queued.
//  start in the same cycle as the done pulse: ignored. Accepted the next cycle.
//  Duration from the accepted-start edge to the done pulse:
//    full transaction = 20 slots = 80*CLK_DIV clk.
//    address NACK     = 11 slots = 44*CLK_DIV clk.
//  data_out holds its value until the next read begins shifting.
//  An inout line reading 'z' or 'x' in simulation counts as 1 (pull-up).
// TESTING
//  1) CLK_DIV=4, write addr 7'h50, data 8'hA5, slave ACKs both
//     -> SDA bits 1010000_0 then 10100101; done at +320 clk; ack_error=0.
//  2) CLK_DIV=4, read addr 7'h50, slave returns 8'h3C, ack_master=0
//     -> data_out=8'h3C; SDA released in the ACK slot; done at +320 clk.
//  3) Address NACK (no slave at 7'h22) -> ack_error=1; STOP follows ADDR_ACK; done at +176 clk.
//  4) Write with a data-byte NACK -> ack_error=1, done at +320 clk.
//     A following good write clears ack_error when its start is accepted.
//  5) Pulse start again mid-transaction -> no effect on the waveform; busy stays high until done.
//  6) Assert reset during the ADDR 4th bit -> next clk scl=z, sda=z, busy=0, done=0.
//     A new start after reset completes normally.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte open-drain I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Each bit slot is four quarters of CLK_DIV clk; lines are only ever pulled low or released.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       rw,
    input  logic [7:0] data_in,
    input  logic       ack_master,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       q_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       addr_sh_reg;
    logic [7:0]       wr_sh_reg;
    logic             rw_reg;
    logic [7:0]       data_out_reg;
    logic             ack_error_reg;
    logic             done_reg;
    logic             sample_reg;
    logic             scl_low_reg, sda_low_reg;
    logic             scl_low_next, sda_low_next;
    logic             tick, slot_end, sample_pt, accept, sda_in, data_q_low;

    // Released bus reads as 1 (pull-up), including z/x in simulation.
    assign sda_in     = (sda !== 1'b0);
    assign scl        = scl_low_reg ? 1'b0 : 1'bz;
    assign sda        = sda_low_reg ? 1'b0 : 1'bz;

    assign tick       = (div_reg == DIV_LAST);
    assign slot_end   = tick && (q_reg == 2'd3);
    assign sample_pt  = tick && (q_reg == 2'd1);
    assign data_q_low = (q_reg == 2'd0) || (q_reg == 2'd3);

    assign data_out   = data_out_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = done_reg;
    assign ack_error  = ack_error_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // A start coinciding with the done pulse is not taken.
                if (start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end
            end
            S_START:     if (slot_end) state_next = S_ADDR;
            S_ADDR:      if (slot_end && bit_reg == 3'd7) state_next = S_ADDR_ACK;
            S_ADDR_ACK:  if (slot_end) state_next = sample_reg ? S_STOP : (rw_reg ? S_READ : S_WRITE);
            S_WRITE:     if (slot_end && bit_reg == 3'd7) state_next = S_WRITE_ACK;
            S_WRITE_ACK: if (slot_end) state_next = S_STOP;
            S_READ:      if (slot_end && bit_reg == 3'd7) state_next = S_READ_ACK;
            S_READ_ACK:  if (slot_end) state_next = S_STOP;
            S_STOP:      if (slot_end) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        scl_low_next = 1'b0;
        sda_low_next = 1'b0;
        case (state_reg)
            S_START: begin
                scl_low_next = (q_reg == 2'd3);
                sda_low_next = (q_reg != 2'd0);
            end
            S_ADDR: begin
                scl_low_next = data_q_low;
                sda_low_next = !addr_sh_reg[7];
            end
            S_WRITE: begin
                scl_low_next = data_q_low;
                sda_low_next = !wr_sh_reg[7];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ: scl_low_next = data_q_low;
            S_READ_ACK: begin
                scl_low_next = data_q_low;
                sda_low_next = ack_master;
            end
            S_STOP: begin
                // Rising SDA in q2 while SCL is high forms the STOP condition.
                scl_low_next = (q_reg == 2'd0);
                sda_low_next = (q_reg == 2'd0) || (q_reg == 2'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg       <= '0;
            q_reg         <= 2'd0;
            bit_reg       <= 3'd0;
            addr_sh_reg   <= 8'h00;
            wr_sh_reg     <= 8'h00;
            rw_reg        <= 1'b0;
            data_out_reg  <= 8'h00;
            ack_error_reg <= 1'b0;
            done_reg      <= 1'b0;
            sample_reg    <= 1'b1;
            scl_low_reg   <= 1'b0;
            sda_low_reg   <= 1'b0;
        end else begin
            done_reg    <= (state_reg == S_STOP) && slot_end;
            scl_low_reg <= scl_low_next;
            sda_low_reg <= sda_low_next;
            if (state_reg == S_IDLE) begin
                div_reg <= '0;
                q_reg   <= 2'd0;
                bit_reg <= 3'd0;
            end else begin
                div_reg <= tick ? '0 : div_reg + 1'b1;
                if (tick)     q_reg   <= q_reg + 2'd1;
                if (slot_end) bit_reg <= (state_next != state_reg) ? 3'd0 : bit_reg + 3'd1;
            end
            if (accept) begin
                addr_sh_reg   <= {slave_addr, rw};
                wr_sh_reg     <= data_in;
                rw_reg        <= rw;
                ack_error_reg <= 1'b0;
            end
            if (sample_pt) sample_reg <= sda_in;
            if (slot_end && state_reg == S_ADDR)  addr_sh_reg <= {addr_sh_reg[6:0], 1'b0};
            if (slot_end && state_reg == S_WRITE) wr_sh_reg   <= {wr_sh_reg[6:0], 1'b0};
            if (sample_pt && state_reg == S_READ) data_out_reg <= {data_out_reg[6:0], sda_in};
            if (slot_end && sample_reg &&
                (state_reg == S_ADDR_ACK || state_reg == S_WRITE_ACK))
                ack_error_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: behavioural I2C slave on the bus plus a
// transaction-level model predicting bus bits, duration, ack_error and data_out.
module tb_i2c_master;
    localparam int CLK_DIV = 4;
    localparam int LIMIT   = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ack_master = 1'b0;
    logic [7:0] data_out;
    logic       busy, done, ack_error;
    wire        scl, sda;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .slave_addr(slave_addr), .rw(rw),
        .data_in(data_in), .ack_master(ack_master), .data_out(data_out), .busy(busy),
        .done(done), .ack_error(ack_error), .scl(scl), .sda(sda)
    );

    pullup pu_scl (scl);
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    // Behavioural slave: detects START/STOP, records every bit seen on an SCL rise,
    // and drives ACKs / read data after SCL falls.
    logic [6:0]  slv_addr = 7'h50;
    logic        slv_nack_data = 1'b0;
    logic [7:0]  slv_rd_byte = 8'h00;
    logic        slv_clr = 1'b0;
    logic        slv_sda_low = 1'b0;
    logic        slv_active = 1'b0;
    logic [7:0]  slv_hdr = 8'h00;
    logic [31:0] bus_vec = 32'h0;
    int          bus_n = 0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1, s_c, s_d;

    assign sda = slv_sda_low ? 1'b0 : 1'bz;

    always @(scl or sda or slv_clr) begin
        s_c = (scl !== 1'b0);
        s_d = (sda !== 1'b0);
        if (slv_clr) begin
            slv_active  = 1'b0;
            slv_sda_low = 1'b0;
        end else if (prev_scl && s_c && prev_sda && !s_d) begin
            slv_active  = 1'b1;
            slv_sda_low = 1'b0;
            bus_vec     = 32'h0;
            bus_n       = 0;
        end else if (prev_scl && s_c && !prev_sda && s_d) begin
            slv_active  = 1'b0;
            slv_sda_low = 1'b0;
        end else if (slv_active && !prev_scl && s_c) begin
            bus_vec = {bus_vec[30:0], s_d};
            bus_n++;
            if (bus_n == 8) slv_hdr = bus_vec[7:0];
        end else if (slv_active && prev_scl && !s_c) begin
            slv_sda_low = 1'b0;
            if (bus_n >= 8 && slv_hdr[7:1] == slv_addr) begin
                if (bus_n == 8) slv_sda_low = 1'b1;
                else if (slv_hdr[0] && bus_n >= 9 && bus_n <= 16) slv_sda_low = !slv_rd_byte[16 - bus_n];
                else if (!slv_hdr[0] && bus_n == 17) slv_sda_low = !slv_nack_data;
            end
        end
        prev_scl = s_c;
        prev_sda = s_d;
    end

    // Transaction-level reference model.
    logic [31:0] exp_vec;
    int          exp_n, exp_cycles;
    logic        exp_err;
    logic [7:0]  model_dout = 8'h00;

    function automatic void predict(input logic [6:0] a, input logic r, input logic [7:0] d, input logic am);
        logic [7:0] hdr, byte_v;
        hdr     = {a, r};
        exp_vec = {24'h0, hdr};
        exp_n   = 8;
        if (a != slv_addr) begin
            exp_vec    = {exp_vec[29:0], 1'b1, 1'b0};  // NACK, then SDA low at STOP's SCL rise
            exp_n      = 10;
            exp_cycles = 44 * CLK_DIV;
            exp_err    = 1'b1;
            return;
        end
        byte_v  = r ? slv_rd_byte : d;
        exp_vec = {exp_vec[22:0], 1'b0, byte_v};
        exp_vec = {exp_vec[29:0], (r ? !am : slv_nack_data), 1'b0};
        exp_n   = 19;
        exp_err = r ? 1'b0 : slv_nack_data;
        if (r) model_dout = slv_rd_byte;
        exp_cycles = 80 * CLK_DIV;
    endfunction

    // Observations from one transaction.
    int          obs_cycles, obs_n;
    logic        obs_timeout, obs_busy_drop, obs_err, obs_err_at_accept;
    logic [7:0]  obs_dout;
    logic [31:0] obs_vec;

    task automatic exec_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                            input logic am, input bit poke);
        @(negedge clk);
        slave_addr = a; rw = r; data_in = d; ack_master = am; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs_cycles = 0;
        obs_busy_drop = 1'b0;
        obs_err_at_accept = ack_error;
        while (done !== 1'b1 && obs_cycles < LIMIT) begin
            if (busy !== 1'b1) obs_busy_drop = 1'b1;
            start = (poke && (obs_cycles % 37 == 5)) ? 1'b1 : 1'b0;
            @(negedge clk);
            obs_cycles++;
        end
        start = 1'b0;
        obs_timeout = (done !== 1'b1);
        obs_err  = ack_error;
        obs_dout = data_out;
        obs_vec  = bus_vec;
        obs_n    = bus_n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (ack_error !== 1'b0) begin n_bad++; $display("FAIL reset_ack_error: got %b want 0", ack_error); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (scl !== 1'b1 || sda !== 1'b1) begin n_bad++; $display("FAIL reset_lines: got scl=%b sda=%b want 1 1", scl, sda); end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_write();
        slv_addr = 7'h50; slv_nack_data = 1'b0;
        predict(7'h50, 1'b0, 8'hA5, 1'b0);
        exec_txn(7'h50, 1'b0, 8'hA5, 1'b0, 0);
        n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL write_timeout: no done within %0d clk", LIMIT); end
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL write_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL write_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        n_cmp++; if (obs_err !== exp_err) begin n_bad++; $display("FAIL write_ack_error: got %b want %b", obs_err, exp_err); end
        n_cmp++; if (obs_busy_drop) begin n_bad++; $display("FAIL write_busy: got busy low before done want high"); end
        $display("test_write addr=50 data=A5 cycles=%0d bits=%h", obs_cycles, obs_vec);
    endtask

    task automatic test_read();
        slv_addr = 7'h50; slv_rd_byte = 8'h3C;
        predict(7'h50, 1'b1, 8'h00, 1'b0);
        exec_txn(7'h50, 1'b1, 8'h00, 1'b0, 0);
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL read_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL read_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        n_cmp++; if (obs_dout !== 8'h3C) begin n_bad++; $display("FAIL read_data_out: got %h want 3c", obs_dout); end
        n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL read_ack_error: got %b want 0", obs_err); end
        $display("test_read addr=50 data_out=%h cycles=%0d", obs_dout, obs_cycles);
    endtask

    task automatic test_addr_nack();
        predict(7'h22, 1'b0, 8'h5A, 1'b0);
        exec_txn(7'h22, 1'b0, 8'h5A, 1'b0, 0);
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL nack_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL nack_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL nack_ack_error: got %b want 1", obs_err); end
        n_cmp++; if (obs_dout !== model_dout) begin n_bad++; $display("FAIL nack_data_out: got %h want %h", obs_dout, model_dout); end
        $display("test_addr_nack addr=22 cycles=%0d ack_error=%b", obs_cycles, obs_err);
    endtask

    task automatic test_data_nack();
        slv_nack_data = 1'b1;
        predict(7'h50, 1'b0, 8'hC3, 1'b0);
        exec_txn(7'h50, 1'b0, 8'hC3, 1'b0, 0);
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL dnack_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL dnack_ack_error: got %b want 1", obs_err); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL dnack_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        $display("test_data_nack cycles=%0d ack_error=%b", obs_cycles, obs_err);
        slv_nack_data = 1'b0;
        predict(7'h50, 1'b0, 8'h0F, 1'b0);
        exec_txn(7'h50, 1'b0, 8'h0F, 1'b0, 0);
        n_cmp++; if (obs_err_at_accept !== 1'b0) begin n_bad++; $display("FAIL dnack_clear_on_start: got %b want 0", obs_err_at_accept); end
        n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL dnack_followup_err: got %b want 0", obs_err); end
        $display("test_data_nack follow-up cycles=%0d ack_error=%b", obs_cycles, obs_err);
    endtask

    task automatic test_busy_ignore();
        predict(7'h50, 1'b0, 8'h96, 1'b0);
        exec_txn(7'h50, 1'b0, 8'h96, 1'b0, 1);
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL busy_ign_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL busy_ign_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        n_cmp++; if (obs_busy_drop) begin n_bad++; $display("FAIL busy_ign_busy: got busy low before done want high"); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_ign_not_queued: got busy=%b want 0", busy); end
        $display("test_busy_ignore cycles=%0d", obs_cycles);
    endtask

    task automatic test_back_to_back();
        predict(7'h50, 1'b0, 8'h11, 1'b0);
        exec_txn(7'h50, 1'b0, 8'h11, 1'b0, 0);
        // Request raised during the done cycle: ignored, then taken one clk later.
        slave_addr = 7'h50; rw = 1'b1; ack_master = 1'b1; start = 1'b1;
        slv_rd_byte = 8'hE7;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored_on_done: got busy=%b want 0", busy); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accepted_next: got busy=%b want 1", busy); end
        predict(7'h50, 1'b1, 8'h00, 1'b1);
        obs_cycles = 0;
        while (done !== 1'b1 && obs_cycles < LIMIT) begin
            @(negedge clk);
            obs_cycles++;
        end
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL b2b_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (bus_n != exp_n || bus_vec !== exp_vec) begin n_bad++; $display("FAIL b2b_bits: got %0d/%h want %0d/%h", bus_n, bus_vec, exp_n, exp_vec); end
        n_cmp++; if (data_out !== model_dout) begin n_bad++; $display("FAIL b2b_data_out: got %h want %h", data_out, model_dout); end
        $display("test_back_to_back read data_out=%h cycles=%0d", data_out, obs_cycles);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        slave_addr = 7'h50; rw = 1'b0; data_in = 8'h7E; ack_master = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inside q0 of the fourth address bit (a 0), where both lines are held low.
        repeat (16 * CLK_DIV + 2) @(negedge clk);
        n_cmp++; if (scl !== 1'b0 || sda !== 1'b0) begin n_bad++; $display("FAIL rmid_before: got scl=%b sda=%b want 0 0", scl, sda); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (scl !== 1'b1 || sda !== 1'b1) begin n_bad++; $display("FAIL rmid_lines: got scl=%b sda=%b want 1 1", scl, sda); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rmid_flags: got busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rmid_data_out: got %h want 00", data_out); end
        reset = 1'b0;
        model_dout = 8'h00;
        slv_clr = 1'b1; #1; slv_clr = 1'b0;
        predict(7'h50, 1'b0, 8'h81, 1'b0);
        exec_txn(7'h50, 1'b0, 8'h81, 1'b0, 0);
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL rmid_after_duration: got %0d want %0d", obs_cycles, exp_cycles); end
        n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL rmid_after_bits: got %0d/%h want %0d/%h", obs_n, obs_vec, exp_n, exp_vec); end
        $display("test_reset_mid recovery cycles=%0d", obs_cycles);
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic       r, am;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            a  = ($urandom_range(0, 1) == 0) ? slv_addr : 7'($urandom);
            r  = 1'($urandom);
            am = 1'($urandom);
            d  = 8'($urandom);
            slv_rd_byte   = 8'($urandom);
            slv_nack_data = ($urandom_range(0, 3) == 0);
            predict(a, r, d, am);
            exec_txn(a, r, d, am, 0);
            n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("FAIL rand%0d_duration: got %0d want %0d", i, obs_cycles, exp_cycles); end
            n_cmp++; if (obs_n != exp_n || obs_vec !== exp_vec) begin n_bad++; $display("FAIL rand%0d_bits: got %0d/%h want %0d/%h", i, obs_n, obs_vec, exp_n, exp_vec); end
            n_cmp++; if (obs_err !== exp_err) begin n_bad++; $display("FAIL rand%0d_ack_error: got %b want %b", i, obs_err, exp_err); end
            n_cmp++; if (obs_dout !== model_dout) begin n_bad++; $display("FAIL rand%0d_data_out: got %h want %h", i, obs_dout, model_dout); end
            $display("test_random %0d addr=%h rw=%b data=%h cycles=%0d err=%b dout=%h", i, a, r, d, obs_cycles, obs_err, obs_dout);
        end
        slv_nack_data = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
